rst_sequencer: RTL and testbench

Parametrised board-level reset controller that replaces ad-hoc counter-based reset generation in the top-level wrappers. It synchronises and debounces an asynchronous reset button, monitors an asynchronous PLL lock, accepts a software reset pulse from the SoC, and releases `NUM_DOMAINS` active-high reset outputs in index order with programmable hold and gap times. It also records the cause of the last reset. It sits between the PLL/board pins and `soc`; `o_rst[0]` normally drives `sys_rst` of the core.

---
 rtl/rst_pkg.sv | 19 +
 rtl/rst_debounce.sv | 53 +++++
 rtl/rst_sequencer.sv | 140 ++++++++++++++
 tb/tb_rst_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rst_pkg.sv
// Shared types for the board reset sequencer: reset-cause encoding and
// sequencer FSM states.
package rst_pkg;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_PLL = 2'd1,
    CAUSE_BTN = 2'd2,
    CAUSE_SW  = 2'd3
  } rst_cause_e;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } rst_state_e;

endpackage

// File: rtl/rst_debounce.sv
// Reset-button conditioning: multi-flop synchroniser followed by a
// consecutive-cycle debounce counter producing a registered press flag.
module rst_debounce
  import rst_pkg::*;
#(
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_press,
  output logic o_act
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   act_q, act_d;
  logic                   press_s;

  assign press_s = sync_q[SYNC_STAGES-1];
  assign o_act   = act_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_press};
    cnt_d  = cnt_q;
    act_d  = act_q;
    if (!press_s) begin
      cnt_d = '0;
      act_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      // Counter parks at its last value while the press is held.
      act_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      act_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Board reset controller: merges button, PLL lock and software reset
// triggers, then releases NUM_DOMAINS resets in index order.
module rst_sequencer
  import rst_pkg::*;
#(
  parameter int NUM_DOMAINS     = 4,
  parameter int SYNC_STAGES     = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 4500000,
  parameter int RELEASE_GAP     = 16,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   i_btn,
  input  logic                   i_pll_locked,
  input  logic                   i_sw_rst_req,
  output logic [NUM_DOMAINS-1:0] o_rst,
  output logic                   o_ready,
  output logic [1:0]             o_cause
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(RELEASE_GAP + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RELEASE_GAP - 1);

  logic                   btn_press;
  logic                   btn_act;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic                   lock_s;
  logic                   trig;

  rst_state_e             state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                   ready_q, ready_d;
  rst_cause_e             cause_q, cause_d;

  assign btn_press = BTN_ACTIVE_LOW ? ~i_btn : i_btn;

  rst_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .i_press(btn_press),
    .o_act  (btn_act)
  );

  // Lock synchroniser clears to 0, so the PLL reads unlocked while it fills.
  assign lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], i_pll_locked};
  assign lock_s      = lock_sync_q[SYNC_STAGES-1];
  assign trig        = btn_act | ~lock_s | i_sw_rst_req;

  assign o_rst   = rst_out_q;
  assign o_ready = ready_q;
  assign o_cause = cause_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rst_out_d  = rst_out_q;
    ready_d    = ready_q;
    cause_d    = cause_q;

    if (trig) begin
      state_d    = ST_ASSERT;
      hold_cnt_d = '0;
      gap_cnt_d  = '0;
      rst_out_d  = '1;
      ready_d    = 1'b0;
      cause_d    = !lock_s ? CAUSE_PLL : (btn_act ? CAUSE_BTN : CAUSE_SW);
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
        end
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            // Releases shift out from bit 0 upward; all-zero means done.
            rst_out_d  = rst_out_q << 1;
            hold_cnt_d = '0;
            gap_cnt_d  = '0;
            if (rst_out_d == '0) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_RELEASE: begin
          if (gap_cnt_q == GAP_LAST) begin
            rst_out_d = rst_out_q << 1;
            gap_cnt_d = '0;
            if (rst_out_d == '0) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        ST_RUN: begin
          rst_out_d = '0;
          ready_d   = 1'b1;
        end
        default: state_d = ST_ASSERT;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lock_sync_q <= '0;
      state_q     <= ST_ASSERT;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      rst_out_q   <= '1;
      ready_q     <= 1'b0;
      cause_q     <= CAUSE_POR;
    end else begin
      lock_sync_q <= lock_sync_d;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      cause_q     <= cause_d;
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: stimulus queues edge-stamped expected
// outputs, a negedge monitor pops and compares them.
module tb_rst_sequencer;

  localparam int N  = 3;
  localparam int SS = 2;
  localparam int DB = 5;
  localparam int H  = 8;
  localparam int G  = 4;

  localparam logic [1:0] C_POR = 2'd0;
  localparam logic [1:0] C_PLL = 2'd1;
  localparam logic [1:0] C_BTN = 2'd2;
  localparam logic [1:0] C_SW  = 2'd3;

  logic         clk = 1'b0;
  logic         sys_rst;
  logic         i_btn;
  logic         i_pll_locked;
  logic         i_sw_rst_req;
  logic [N-1:0] o_rst;
  logic         o_ready;
  logic [1:0]   o_cause;

  always #5 clk = ~clk;

  rst_sequencer #(
    .NUM_DOMAINS    (N),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (H),
    .RELEASE_GAP    (G),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk     (clk),
    .sys_rst     (sys_rst),
    .i_btn       (i_btn),
    .i_pll_locked(i_pll_locked),
    .i_sw_rst_req(i_sw_rst_req),
    .o_rst       (o_rst),
    .o_ready     (o_ready),
    .o_cause     (o_cause)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] rst;
    logic         rdy;
    logic [1:0]   cause;
    string        name;
  } exp_t;

  exp_t q[$];
  int   ec    = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic fin   = 1'b0;

  always @(posedge clk) ec <= ec + 1;

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= ec) begin
      e = q.pop_front();
      n_chk++;
      if (e.cyc != ec || o_rst !== e.rst || o_ready !== e.rdy || o_cause !== e.cause) begin
        n_err++;
        $display("FAIL %s edge %0d: got o_rst=%b o_ready=%b o_cause=%0d, required o_rst=%b o_ready=%b o_cause=%0d at edge %0d",
                 e.name, ec, o_rst, o_ready, o_cause, e.rst, e.rdy, e.cause, e.cyc);
      end
    end
    if (fin && q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      n_err++;
      $display("FAIL %s: expectation for edge %0d never compared, run ended at edge %0d", e.name, e.cyc, ec);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, edge=%0d errors=%0d", ec, n_err);
    $fatal(1);
  end

  task automatic push(input int cyc, input logic [N-1:0] r, input logic rdy,
                      input logic [1:0] c, input string nm);
    exp_t e;
    e.cyc = cyc; e.rst = r; e.rdy = rdy; e.cause = c; e.name = nm;
    q.push_back(e);
  endtask

  task automatic push_range(input int a, input int b, input logic [N-1:0] r,
                            input logic rdy, input logic [1:0] c, input string nm);
    for (int i = a; i <= b; i++) push(i, r, rdy, c, nm);
  endtask

  // Release sequence after E0: o_rst[k] falls at E0 + H + k*G.
  task automatic push_seq(input int e0, input logic [1:0] c, input int last, input string nm);
    for (int e = e0; e <= last; e++) begin
      int d;
      d = e - e0;
      if (d < H)              push(e, 3'b111, 1'b0, c, nm);
      else if (d < H + G)     push(e, 3'b110, 1'b0, c, nm);
      else if (d < H + 2 * G) push(e, 3'b100, 1'b0, c, nm);
      else                    push(e, 3'b000, 1'b1, c, nm);
    end
  endtask

  task automatic wait_ec(input int n);
    while (ec < n) @(negedge clk);
  endtask

  initial begin
    int m;
    int p;
    int seq_len;
    seq_len      = H + 2 * G + 2;
    sys_rst      = 1'b1;
    i_btn        = 1'b1;
    i_pll_locked = 1'b1;
    i_sw_rst_req = 1'b0;

    // Power-on: reset over absolute edges 1..4, relative edge r = abs - 4.
    push_range(1, 4, 3'b111, 1'b0, C_POR, "por_in_reset");
    push_range(5, 6, 3'b111, 1'b0, C_PLL, "por_sync_fill");
    push_seq(7, C_PLL, 7 + seq_len, "por_seq");
    wait_ec(4);
    sys_rst = 1'b0;
    wait_ec(7 + seq_len + 1);

    // Short presses (3 and DB-1 cycles) must not trigger.
    for (int len = 3; len <= DB - 1; len++) begin
      m = ec;
      push_range(m + 1, m + 12, 3'b000, 1'b1, C_PLL, "btn_short_ignored");
      i_btn = 1'b0;
      wait_ec(m + len);
      i_btn = 1'b1;
      wait_ec(m + 13);
    end

    // 7-cycle press: btn_act at m+7, o_rst high at m+8, E0 = m+11.
    m = ec;
    push_range(m + 1, m + 7, 3'b000, 1'b1, C_PLL, "btn_pre");
    push_range(m + 8, m + 10, 3'b111, 1'b0, C_BTN, "btn_assert");
    push_seq(m + 11, C_BTN, m + 19, "btn_seq");
    i_btn = 1'b0;
    wait_ec(m + 7);
    i_btn = 1'b1;

    // Software pulse one cycle after o_rst[0] falls (edge m+19).
    wait_ec(m + 19);
    i_sw_rst_req = 1'b1;
    push(m + 20, 3'b111, 1'b0, C_SW, "sw_retrigger");
    push_seq(m + 21, C_SW, m + 21 + seq_len, "sw_seq");
    wait_ec(m + 20);
    i_sw_rst_req = 1'b0;
    wait_ec(m + 22 + seq_len);

    // Software request sampled together with btn_act: button wins.
    m = ec;
    push_range(m + 1, m + 7, 3'b000, 1'b1, C_SW, "prio_pre");
    push_range(m + 8, m + 10, 3'b111, 1'b0, C_BTN, "prio_btn_over_sw");
    push_seq(m + 11, C_BTN, m + 11 + seq_len, "prio_seq");
    i_btn = 1'b0;
    wait_ec(m + 7);
    i_btn = 1'b1;
    i_sw_rst_req = 1'b1;
    wait_ec(m + 8);
    i_sw_rst_req = 1'b0;
    wait_ec(m + 12 + seq_len);

    // Lock lost for 20 cycles: assert at p+3, E0 = p+23.
    p = ec;
    push_range(p + 1, p + 2, 3'b000, 1'b1, C_BTN, "lock_pre");
    push_range(p + 3, p + 22, 3'b111, 1'b0, C_PLL, "lock_lost");
    push_seq(p + 23, C_PLL, p + 35, "lock_seq");
    i_pll_locked = 1'b0;
    wait_ec(p + 20);
    i_pll_locked = 1'b1;

    // sys_rst pulse while o_rst = 100 (edge p+36), then a power-on sequence.
    wait_ec(p + 35);
    sys_rst = 1'b1;
    push(p + 36, 3'b111, 1'b0, C_POR, "por_mid_release");
    push_range(p + 37, p + 38, 3'b111, 1'b0, C_PLL, "por_mid_fill");
    push_seq(p + 39, C_PLL, p + 39 + seq_len, "por_mid_seq");
    wait_ec(p + 36);
    sys_rst = 1'b0;
    wait_ec(p + 40 + seq_len);

    fin = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
